// File: rtl/serial_int_sub_pkg.sv
// Shared definitions for the serial chunked subtractor: FSM encoding and
// default operand/slice widths.
package serial_int_sub_pkg;

  localparam int DEF_BWOP  = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_int_sub_if.sv
// Request/result bundle between a client and the serial subtractor.
interface serial_int_sub_if
  import serial_int_sub_pkg::*;
#(
  parameter int BWOP = DEF_BWOP
) ();

  logic            start;
  logic [BWOP-1:0] a;
  logic [BWOP-1:0] b;
  logic            busy;
  logic            done;
  logic [BWOP-1:0] c;
  logic            borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, c, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, c, borrow_out
  );

endinterface

// File: rtl/acc_int_sub.sv
// One CHUNK-wide slice of a ripple subtractor: d = a - b - borrow_in,
// borrow_out set when the slice result went negative.
module acc_int_sub
  import serial_int_sub_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             borrow_in,
  output logic [CHUNK-1:0] d,
  output logic             borrow_out
);

  // One extra bit on top catches the borrow of the slice difference.
  logic [CHUNK:0] full;

  assign full       = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
  assign d          = full[CHUNK-1:0];
  assign borrow_out = full[CHUNK];

endmodule

// File: rtl/serial_int_sub.sv
// Multi-cycle unsigned subtractor: a - b is computed CHUNK bits per clock,
// LSB slice first, with the result and final borrow published on done.
module serial_int_sub
  import serial_int_sub_pkg::*;
#(
  parameter int BWOP  = DEF_BWOP,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic             clk,
  input logic             rst,
  serial_int_sub_if.slave bus
);

  localparam int N  = BWOP / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            borrow_q;
  logic [BWOP-1:0] a_q;
  logic [BWOP-1:0] b_q;
  logic [BWOP-1:0] diff_q;
  logic [BWOP-1:0] c_q;
  logic            borrow_out_q;
  logic            busy_q;
  logic            done_q;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] slice_d;
  logic             slice_borrow;
  logic [BWOP-1:0]  diff_next;
  logic             last_slice;

  // NOTE: every always_comb output is assigned a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    a_slice   = a_q[int'(cnt)*CHUNK +: CHUNK];
    b_slice   = b_q[int'(cnt)*CHUNK +: CHUNK];
    diff_next = diff_q;
    diff_next[int'(cnt)*CHUNK +: CHUNK] = slice_d;
  end

  assign last_slice = (cnt == CW'(N - 1));

  acc_int_sub #(.CHUNK(CHUNK)) u_slice (
    .a          (a_slice),
    .b          (b_slice),
    .borrow_in  (borrow_q),
    .d          (slice_d),
    .borrow_out (slice_borrow)
  );

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      borrow_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      c_q          <= '0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            cnt      <= '0;
            borrow_q <= 1'b0;
            state    <= BUSY;
            busy_q   <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        BUSY: begin
          // start is deliberately not looked at here; operands stay frozen.
          diff_q   <= diff_next;
          borrow_q <= slice_borrow;
          if (last_slice) begin
            c_q          <= diff_next;
            borrow_out_q <= slice_borrow;
            state        <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.c          = c_q;
  assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_int_sub.sv
// Scoreboard bench for serial_int_sub (BWOP=32, CHUNK=8): expected results
// are queued at start and checked whenever done pulses.
module tb_serial_int_sub;

  localparam int BWOP  = 32;
  localparam int CHUNK = 8;
  localparam int N     = BWOP / CHUNK;

  typedef struct {
    logic [BWOP-1:0] c;
    logic            bo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  serial_int_sub_if #(.BWOP(BWOP)) bus ();

  serial_int_sub #(.BWOP(BWOP), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks     = 0;
  int   errors     = 0;
  int   done_count = 0;
  int   cyc        = 0;
  int   done_cyc[$];
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      done_count++;
      done_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 with nothing pending at cycle %0d, c=%h", cyc, bus.c);
      end else begin
        e = exp_q.pop_front();
        if (bus.c !== e.c || bus.borrow_out !== e.bo) begin
          errors++;
          $display("FAIL result: got c=%h borrow_out=%b, expected c=%h borrow_out=%b",
                   bus.c, bus.borrow_out, e.c, e.bo);
        end
      end
    end
  end

  function automatic exp_t model(input logic [BWOP-1:0] a, input logic [BWOP-1:0] b);
    exp_t e;
    logic [BWOP:0] w;
    w    = {1'b0, a} - {1'b0, b};
    e.c  = w[BWOP-1:0];
    e.bo = (a < b);
    return e;
  endfunction

  task automatic start_op(input logic [BWOP-1:0] a, input logic [BWOP-1:0] b);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int max_cycles, input string tag);
    int k = 0;
    while (done_count < target && k < max_cycles) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (done_count < target) begin
      errors++;
      $display("FAIL %s_timeout: done_count=%0d, expected %0d within %0d cycles",
               tag, done_count, target, max_cycles);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c !== '0 || bus.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b c=%h borrow_out=%b, expected all 0",
               bus.busy, bus.done, bus.c, bus.borrow_out);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_latency();
    int base = done_count;
    start_op(32'h0000_0005, 32'h0000_0003);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.c !== 32'h0) begin
        errors++;
        $display("FAIL busy_phase[%0d]: busy=%b done=%b c=%h, expected busy=1 done=0 c=0",
                 i, bus.busy, bus.done, bus.c);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_latency: busy=%b done=%b, expected busy=0 done=1", bus.busy, bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c !== 32'h2) begin
      errors++;
      $display("FAIL done_pulse_width: busy=%b done=%b c=%h, expected 0 0 00000002",
               bus.busy, bus.done, bus.c);
    end
    checks++;
    if (done_count !== base + 1) begin
      errors++;
      $display("FAIL latency_done_count: got %0d, expected %0d", done_count, base + 1);
    end
  endtask

  task automatic test_arith();
    logic [BWOP-1:0] va[6];
    logic [BWOP-1:0] vb[6];
    va[0] = 32'h0000_0000; vb[0] = 32'h0000_0001;
    va[1] = 32'h0000_0100; vb[1] = 32'h0000_0001;
    va[2] = 32'h0100_0000; vb[2] = 32'h0000_0001;
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF;
    va[4] = $urandom;      vb[4] = $urandom;
    va[5] = $urandom;      vb[5] = $urandom;
    for (int i = 0; i < 6; i++) begin
      int base = done_count;
      start_op(va[i], vb[i]);
      wait_dones(base + 1, 3 * N, "arith");
    end
  endtask

  task automatic test_ignore_start();
    int base = done_count;
    start_op(32'd10, 32'd4);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 32'd99;
    bus.b     = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    wait_dones(base + 1, 3 * N, "ignore");
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_count !== base + 1 || bus.c !== 32'd6) begin
      errors++;
      $display("FAIL ignore_start: done pulses=%0d c=%h, expected 1 pulse c=00000006",
               done_count - base, bus.c);
    end
  endtask

  task automatic test_reset_mid();
    int base = done_count;
    start_op(32'h0000_1234, 32'h0000_0011);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c !== '0 || bus.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b c=%h borrow_out=%b, expected all 0",
               bus.busy, bus.done, bus.c, bus.borrow_out);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_count !== base || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: done pulses=%0d busy=%b, expected 0 pulses busy=0",
               done_count - base, bus.busy);
    end
    start_op(32'd50, 32'd8);
    wait_dones(base + 1, 3 * N, "post_reset");
  endtask

  task automatic test_back_to_back();
    int base = done_count;
    int nd   = done_cyc.size();
    int k    = 0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 32'd7;
    bus.b     = 32'd2;
    exp_q.push_back(model(32'd7, 32'd2));
    exp_q.push_back(model(32'd7, 32'd2));
    while (done_count < base + 2 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    bus.start = 1'b0;
    checks++;
    if (done_count < base + 2) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d done pulses, expected 2", done_count - base);
    end else begin
      checks++;
      if (done_cyc[nd+1] - done_cyc[nd] !== N + 1) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles between done pulses, expected %0d",
                 done_cyc[nd+1] - done_cyc[nd], N + 1);
      end
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_count !== base + 2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: done pulses=%0d busy=%b, expected 2 pulses busy=0",
               done_count - base, bus.busy);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_latency();
    test_arith();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d expected results never produced", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_int_sub.md
SERIAL_INT_SUB -- requirements
Module: serial_int_sub

Interface
REQ-001 Parameter BWOP, default 32, operand and result width in bits.
REQ-002 Parameter CHUNK, default 8, bits subtracted per cycle; BWOP SHALL be an integer multiple of CHUNK; N = BWOP/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a subtraction; sampled on a rising clk edge.
REQ-006 a  input  BWOP  minuend, unsigned, captured when start is accepted.
REQ-007 b  input  BWOP  subtrahend, unsigned, captured when start is accepted.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse marking that c and borrow_out hold a new result.
REQ-010 c  output  BWOP  registered result (a - b) mod 2^BWOP.
REQ-011 borrow_out  output  1  registered final borrow; 1 iff a < b unsigned.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL be accepted: latch a and b, clear the chunk counter and the borrow flop, and go to BUSY.
REQ-014 In IDLE, start=0 SHALL keep IDLE; in DONE, start=0 SHALL go to IDLE after exactly one cycle.
REQ-015 In BUSY, each edge SHALL subtract one CHUNK slice, LSB slice first, using the registered borrow as borrow-in, store the slice difference and update the borrow flop.
REQ-016 start SHALL be ignored while in BUSY; latched operands SHALL NOT change.
REQ-017 On the N-th BUSY edge, the FSM SHALL go to DONE, load c with the full difference and borrow_out with the final borrow.
REQ-018 Latency: done SHALL be high in the cycle after the N-th edge following the accepting edge, i.e. N cycles after start is sampled.
REQ-019 busy SHALL equal (state == BUSY); done SHALL equal (state == DONE).
REQ-020 c and borrow_out SHALL hold their value from the DONE load until the next completion or reset; they SHALL NOT show partial results while BUSY.
REQ-021 Arithmetic SHALL be unsigned modulo 2^BWOP; the borrow SHALL propagate correctly across every chunk boundary.
REQ-022 A start held high through DONE SHALL begin the next operation with no idle cycle between operations.

Reset
REQ-023 When rst is low, the block SHALL set the state to IDLE and clear the counter, the borrow flop, the operand registers, c, borrow_out, busy and done, independent of clk.
REQ-024 A reset asserted mid-operation SHALL abort the operation with no done pulse; the first edge after rst deasserts SHALL behave as IDLE.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE, BUSY, DONE) and the default BWOP and CHUNK values.
REQ-026 The per-slice arithmetic SHALL be one combinational sub-module, acc_int_sub (CHUNK-bit a, b and borrow-in; difference and borrow-out), instantiated once.
REQ-027 The slice select SHALL be indexed by the chunk counter, of width ceil(log2 N).

Verification (BWOP=32, CHUNK=8, N=4)
REQ-028 a=0x00000005, b=0x00000003, start pulsed -> busy high for 4 cycles, then done=1 for 1 cycle, c=0x00000002, borrow_out=0.
REQ-029 a=0x00000000, b=0x00000001 -> c=0xFFFFFFFF, borrow_out=1.
REQ-030 a=0x00000100, b=0x00000001 (cross-chunk borrow) -> c=0x000000FF, borrow_out=0.
REQ-031 Start a=10, b=4, then start with a=99, b=1 during BUSY -> second start ignored; c=0x00000006 with exactly one done pulse.
REQ-032 rst driven low in the 2nd BUSY cycle -> all outputs immediately 0, no done pulse; a new start after release completes normally.
REQ-033 start held high with a=7, b=2 across DONE -> back-to-back results c=5, each with its own one-cycle done pulse, 5 cycles apart.
